// File: rtl/pe_mac_row_if.sv
// pe_mac_row_if: lane-data, weight-load and result-stream bundle for pe_mac_row.
//   rd_sop              frame start pulse (shared with the PE-feed stage)
//   pe_data_0..7        skewed signed 16-bit lane words (lane i lags lane 0 by i cycles)
//   wt_load/idx/data    weight register write port
//   busy                frame in flight
//   res_vld/sop/eop     framed result qualifiers
//   res_data            signed ACC_W-bit dot product
// slave modport is the MAC row; master modport is its driver/observer.
interface pe_mac_row_if #(
  parameter int unsigned ACC_W = 36
);
  logic               rd_sop;
  logic [15:0]        pe_data_0;
  logic [15:0]        pe_data_1;
  logic [15:0]        pe_data_2;
  logic [15:0]        pe_data_3;
  logic [15:0]        pe_data_4;
  logic [15:0]        pe_data_5;
  logic [15:0]        pe_data_6;
  logic [15:0]        pe_data_7;
  logic               wt_load;
  logic [2:0]         wt_idx;
  logic [15:0]        wt_data;
  logic               busy;
  logic               res_vld;
  logic               res_sop;
  logic               res_eop;
  logic [ACC_W-1:0]   res_data;

  modport master (
    output rd_sop, pe_data_0, pe_data_1, pe_data_2, pe_data_3,
           pe_data_4, pe_data_5, pe_data_6, pe_data_7,
           wt_load, wt_idx, wt_data,
    input  busy, res_vld, res_sop, res_eop, res_data
  );

  modport slave (
    input  rd_sop, pe_data_0, pe_data_1, pe_data_2, pe_data_3,
           pe_data_4, pe_data_5, pe_data_6, pe_data_7,
           wt_load, wt_idx, wt_data,
    output busy, res_vld, res_sop, res_eop, res_data
  );
endinterface

// File: rtl/pe_mac_row.sv
// pe_mac_row: weight-stationary 8-tap systolic MAC row.
// Consumes eight skewed signed 16-bit lane streams and emits one signed dot
// product  res = sum_i w_i * x_i[k]  per frame word as a framed stream.
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset (clears counters, chain, psums, weights)
//   bus     pe_mac_row_if.slave: rd_sop, pe_data_0..7, wt_load/idx/data in;
//           busy, res_vld/sop/eop, res_data out (all registered)
module pe_mac_row #(
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned ACC_W     = 36
) (
  input  logic         clk,
  input  logic         rst_n,
  pe_mac_row_if.slave  bus
);

  localparam int unsigned N_PE     = 8;
  localparam int unsigned DW       = 16;
  localparam int unsigned PW       = 32;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned DLY_W    = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam int unsigned DLY_INIT = (RD_LAT > 1) ? RD_LAT - 2 : 0;

  localparam logic [CNT_W-1:0] WRD_LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [CNT_W-1:0]   wrd_q, wrd_d;
  logic               busy_q, busy_d;
  logic               vld0_c, sop0_c, eop0_c;

  logic [N_PE-1:1]    vld_q, sop_q, eop_q;
  logic [N_PE-1:0]    vld_c, sop_c, eop_c;

  logic               res_vld_q, res_sop_q, res_eop_q;

  logic signed [DW-1:0]    w_q    [N_PE];
  logic signed [DW-1:0]    lane_c [N_PE];
  logic signed [PW-1:0]    prod_c [N_PE];
  logic signed [ACC_W-1:0] psum_q [N_PE];

  // Lane bundle flattened into an indexable array
  assign lane_c[0] = bus.pe_data_0;
  assign lane_c[1] = bus.pe_data_1;
  assign lane_c[2] = bus.pe_data_2;
  assign lane_c[3] = bus.pe_data_3;
  assign lane_c[4] = bus.pe_data_4;
  assign lane_c[5] = bus.pe_data_5;
  assign lane_c[6] = bus.pe_data_6;
  assign lane_c[7] = bus.pe_data_7;

  // Frame sequencer state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dly_q   <= '0;
      wrd_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      wrd_q   <= wrd_d;
      busy_q  <= busy_d;
    end
  end

  // Frame sequencer next state; vld0_c marks lane-0 sample cycles.
  // DRAIN waits for the registered eop so busy covers the last result cycle.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    wrd_d   = wrd_q;
    vld0_c  = 1'b0;
    sop0_c  = 1'b0;
    eop0_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.rd_sop) begin
          wrd_d = '0;
          if (RD_LAT <= 1) begin
            state_d = S_RUN;
          end else begin
            state_d = S_DELAY;
            dly_d   = DLY_W'(DLY_INIT);
          end
        end
      end
      S_DELAY: begin
        if (dly_q == '0) begin
          state_d = S_RUN;
        end else begin
          dly_d = dly_q - DLY_W'(1);
        end
      end
      S_RUN: begin
        vld0_c = 1'b1;
        sop0_c = (wrd_q == '0);
        eop0_c = (wrd_q == WRD_LAST);
        if (wrd_q == WRD_LAST) begin
          state_d = S_DRAIN;
        end else begin
          wrd_d = wrd_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (res_eop_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Valid / sop / eop skew chain: stage i lags stage 0 by i cycles
  assign vld_c = {vld_q, vld0_c};
  assign sop_c = {sop_q, sop0_c};
  assign eop_c = {eop_q, eop0_c};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q     <= '0;
      sop_q     <= '0;
      eop_q     <= '0;
      res_vld_q <= 1'b0;
      res_sop_q <= 1'b0;
      res_eop_q <= 1'b0;
    end else begin
      vld_q     <= vld_c[N_PE-2:0];
      sop_q     <= sop_c[N_PE-2:0];
      eop_q     <= eop_c[N_PE-2:0];
      res_vld_q <= vld_c[N_PE-1];
      res_sop_q <= sop_c[N_PE-1];
      res_eop_q <= eop_c[N_PE-1];
    end
  end

  // Weight registers; writes are locked out while a frame is in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PE; i++) begin
        w_q[i] <= '0;
      end
    end else if (bus.wt_load && !busy_q) begin
      w_q[bus.wt_idx] <= bus.wt_data;
    end
  end

  // PE array: each stage adds its product to the upstream partial sum and
  // zeroes itself outside its valid window, which also keeps res_data at 0
  // whenever res_vld is low.
  for (genvar i = 0; i < N_PE; i++) begin : g_pe
    logic signed [ACC_W-1:0] psum_in;

    if (i == 0) begin : g_first
      assign psum_in = '0;
    end else begin : g_rest
      assign psum_in = psum_q[i-1];
    end

    assign prod_c[i] = PW'(w_q[i]) * PW'(lane_c[i]);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        psum_q[i] <= '0;
      end else if (vld_c[i]) begin
        psum_q[i] <= psum_in + ACC_W'(prod_c[i]);
      end else begin
        psum_q[i] <= '0;
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.res_vld  = res_vld_q;
  assign bus.res_sop  = res_sop_q;
  assign bus.res_eop  = res_eop_q;
  assign bus.res_data = psum_q[N_PE-1];

endmodule

// File: tb/tb_pe_mac_row.sv
// tb_pe_mac_row: scoreboard bench for pe_mac_row. Instance A uses default
// parameters, instance B uses RD_LAT=1 / FRAME_LEN=1. Stimulus pushes
// hand-computed expected results; negedge monitors pop and compare.
module tb_pe_mac_row;

  localparam int unsigned ACC_W = 36;
  localparam int unsigned RLA   = 2;
  localparam int unsigned FLA   = 16;
  localparam int unsigned RLB   = 1;
  localparam int unsigned FLB   = 1;

  typedef struct packed {
    int               t;
    logic             sop;
    logic             eop;
    logic [ACC_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pe_mac_row_if #(.ACC_W(ACC_W)) ba ();
  pe_mac_row_if #(.ACC_W(ACC_W)) bb ();

  pe_mac_row #(.RD_LAT(RLA), .FRAME_LEN(FLA), .ACC_W(ACC_W)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ba)
  );

  pe_mac_row #(.RD_LAT(RLB), .FRAME_LEN(FLB), .ACC_W(ACC_W)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bb)
  );

  int          ecnt = 0;
  int          fa   = -1000;
  int          fb   = -1000;
  int          nvec = 0;
  int          nmis = 0;
  bit          mon_en = 1'b0;
  logic [15:0] xw [8][16];
  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        ea, eb;

  // Index of the next sampling edge
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s @cycle %0d: got %0h, required %0h", nm, ecnt, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lane_word(input int i);
    int k;
    k = ecnt - fa - int'(RLA) - i;
    if (k >= 0 && k < int'(FLA)) return xw[i][k];
    return 16'($urandom);
  endfunction

  // Lane feed for A: word k of lane i on cycle fa+RLA+i+k, random otherwise
  always begin
    ba.pe_data_0 = lane_word(0);
    ba.pe_data_1 = lane_word(1);
    ba.pe_data_2 = lane_word(2);
    ba.pe_data_3 = lane_word(3);
    ba.pe_data_4 = lane_word(4);
    ba.pe_data_5 = lane_word(5);
    ba.pe_data_6 = lane_word(6);
    ba.pe_data_7 = lane_word(7);
    @(posedge clk);
    #1;
  end

  // Monitor A
  always @(negedge clk) begin
    if (mon_en) begin
      if (ba.res_vld === 1'b1) begin
        if (qa.size() == 0) begin
          nvec++;
          nmis++;
          $display("FAIL a_unexpected: got res_vld=1 at cycle %0d, required no result", ecnt);
        end else begin
          ea = qa.pop_front();
          chk("a_time", 64'(ecnt), 64'(ea.t));
          chk("a_data", 64'(ba.res_data), 64'(ea.data));
          chk("a_sop", 64'(ba.res_sop), 64'(ea.sop));
          chk("a_eop", 64'(ba.res_eop), 64'(ea.eop));
        end
      end else begin
        chk("a_idle", {26'd0, ba.res_sop, ba.res_eop, ba.res_data}, 64'd0);
        if (qa.size() > 0 && qa[0].t <= ecnt) begin
          ea = qa.pop_front();
          chk("a_missing_vld", 64'(ba.res_vld), 64'd1);
        end
      end
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (mon_en) begin
      if (bb.res_vld === 1'b1) begin
        if (qb.size() == 0) begin
          nvec++;
          nmis++;
          $display("FAIL b_unexpected: got res_vld=1 at cycle %0d, required no result", ecnt);
        end else begin
          eb = qb.pop_front();
          chk("b_time", 64'(ecnt), 64'(eb.t));
          chk("b_data", 64'(bb.res_data), 64'(eb.data));
          chk("b_sop", 64'(bb.res_sop), 64'(eb.sop));
          chk("b_eop", 64'(bb.res_eop), 64'(eb.eop));
        end
      end else begin
        chk("b_idle", {26'd0, bb.res_sop, bb.res_eop, bb.res_data}, 64'd0);
        if (qb.size() > 0 && qb[0].t <= ecnt) begin
          eb = qb.pop_front();
          chk("b_missing_vld", 64'(bb.res_vld), 64'd1);
        end
      end
    end
  end

  task automatic load_a(input int idx, input logic [15:0] val);
    ba.wt_load = 1'b1;
    ba.wt_idx  = 3'(idx);
    ba.wt_data = val;
    tick();
    ba.wt_load = 1'b0;
  endtask

  task automatic load_all_a(input logic [15:0] val);
    for (int i = 0; i < 8; i++) load_a(i, val);
  endtask

  task automatic start_a();
    ba.rd_sop = 1'b1;
    fa = ecnt;
    tick();
    ba.rd_sop = 1'b0;
  endtask

  task automatic wait_a(input int c);
    while (ecnt - fa < c) tick();
  endtask

  // Expected frame: data = base + step*k at cycle fa+RLA+8+k
  task automatic push_a(input longint base, input longint step);
    for (int k = 0; k < int'(FLA); k++) begin
      qa.push_back('{t: fa + int'(RLA) + 8 + k, sop: (k == 0), eop: (k == int'(FLA) - 1),
                     data: ACC_W'(base + step * longint'(k))});
    end
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 16; k++) xw[i][k] = 16'(i + k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ba.rd_sop = 1'b0; ba.wt_load = 1'b0; ba.wt_idx = '0; ba.wt_data = '0;
    bb.rd_sop = 1'b0; bb.wt_load = 1'b0; bb.wt_idx = '0; bb.wt_data = '0;
    bb.pe_data_0 = 16'd1; bb.pe_data_1 = 16'd1; bb.pe_data_2 = 16'd1; bb.pe_data_3 = 16'd1;
    bb.pe_data_4 = 16'd1; bb.pe_data_5 = 16'd1; bb.pe_data_6 = 16'd1; bb.pe_data_7 = 16'd1;
    fill_ramp();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // Reset state
    chk("rst_busy_a", 64'(ba.busy), 64'd0);
    chk("rst_vld_a", 64'(ba.res_vld), 64'd0);
    chk("rst_busy_b", 64'(bb.busy), 64'd0);

    // Ramp: all weights 1, lane i word k = i+k -> 28+8k
    load_all_a(16'd1);
    fill_ramp();
    chk("busy_c0", 64'(ba.busy), 64'd0);
    start_a();
    push_a(28, 8);
    wait_a(1);  chk("busy_c1", 64'(ba.busy), 64'd1);
    wait_a(25); chk("busy_c25", 64'(ba.busy), 64'd1);
    wait_a(26); chk("busy_c26", 64'(ba.busy), 64'd0);

    // Signed extremes: (-32768)*(-32768)*8 = 2^33
    load_all_a(16'h8000);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 16; k++) xw[i][k] = 16'h8000;
    start_a();
    push_a(64'h2_0000_0000, 0);
    wait_a(26);

    // (-1)*(-32768)*8 = 262144
    load_all_a(16'hFFFF);
    start_a();
    push_a(262144, 0);
    wait_a(26);

    // Single tap on lane 3: w3=5, lane 3 word k = k -> 5k
    load_all_a(16'd0);
    load_a(3, 16'd5);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 16; k++) xw[i][k] = (i == 3) ? 16'(k) : 16'($urandom);
    start_a();
    push_a(0, 5);
    wait_a(26);

    // Protocol: rd_sop and wt_load while busy are ignored
    load_all_a(16'd1);
    fill_ramp();
    start_a();
    push_a(28, 8);
    wait_a(12);
    ba.rd_sop = 1'b1; tick(); ba.rd_sop = 1'b0;
    wait_a(15);
    ba.wt_load = 1'b1; ba.wt_idx = 3'd0; ba.wt_data = 16'd7; tick(); ba.wt_load = 1'b0;
    wait_a(25);
    chk("busy_eop_cycle", 64'(ba.busy), 64'd1);
    ba.rd_sop = 1'b1; tick(); ba.rd_sop = 1'b0;
    chk("eop_sop_ignored", 64'(ba.busy), 64'd0);
    start_a();
    push_a(28, 8);
    wait_a(26);

    // Mid-frame reset at cycle 14
    start_a();
    push_a(28, 8);
    wait_a(14);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    qa.delete();
    chk("mrst_busy", 64'(ba.busy), 64'd0);
    chk("mrst_vld", 64'(ba.res_vld), 64'd0);
    chk("mrst_flags", {62'd0, ba.res_sop, ba.res_eop}, 64'd0);
    chk("mrst_data", 64'(ba.res_data), 64'd0);
    repeat (30) tick();
    start_a();
    push_a(0, 0);
    wait_a(26);

    // Instance B: RD_LAT=1, FRAME_LEN=1, weights 1, data 1 -> single 8 at cycle 9
    for (int i = 0; i < 8; i++) begin
      bb.wt_load = 1'b1; bb.wt_idx = 3'(i); bb.wt_data = 16'd1; tick();
    end
    bb.wt_load = 1'b0;
    bb.rd_sop = 1'b1;
    fb = ecnt;
    tick();
    bb.rd_sop = 1'b0;
    qb.push_back('{t: fb + int'(RLB) + 8, sop: 1'b1, eop: 1'b1, data: ACC_W'(8)});
    chk("b_busy_c1", 64'(bb.busy), 64'd1);
    while (ecnt - fb < 9) tick();
    chk("b_busy_c9", 64'(bb.busy), 64'd1);
    tick();
    chk("b_busy_c10", 64'(bb.busy), 64'd0);

    repeat (5) tick();
    chk("a_queue_empty", 64'(qa.size()), 64'd0);
    chk("b_queue_empty", 64'(qb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
